// File: rtl/i2s_rx_deserialiser.sv
// I2S receive deserialiser: shifts sd into per-channel registers using an external slot counter
// and latches complete left/right words. Define I2S_RX_READY_EN to add the one-cycle `ready` output.
module i2s_rx_deserialiser #(
   parameter int BITS   = 24,
   parameter int CLOCKS = 64
) (
   input  logic            ck,
   input  logic            rst_n,
   input  logic            sample,
   input  logic [5:0]      frame_posn,
   input  logic            sd,
   output logic [BITS-1:0] left,
   output logic [BITS-1:0] right
`ifdef I2S_RX_READY_EN
   ,
   output logic            ready
`endif
);

   localparam int            PW     = $clog2(CLOCKS);
   localparam logic [PW-1:0] BITS_P = PW'(BITS);
   localparam logic [PW-1:0] LAST_P = PW'(BITS - 1);
   localparam logic [PW-1:0] ZERO_P = PW'(0);
   localparam logic [PW-1:0] ONE_P  = PW'(1);

   logic [PW-1:0]   pos_s;
   logic [PW-1:0]   d_s;
   logic [PW-1:0]   k_s;
   logic            right_ch_s;
   logic            capture_l_s;
   logic            capture_r_s;
   logic            latch_l_s;
   logic            latch_r_s;
   logic [BITS-1:0] left_sh_r;
   logic [BITS-1:0] right_sh_r;
   logic [BITS-1:0] left_nxt_s;
   logic [BITS-1:0] right_nxt_s;
   logic            left_arm_r;
   logic            right_arm_r;

   // Slot decode: one-slot I2S delay, channel select and bit index within the channel.
   // A channel only latches once its MSB has been seen since reset, so partial words are dropped.
   always_comb begin
      pos_s       = frame_posn[PW-1:0];
      d_s         = pos_s - ONE_P;
      right_ch_s  = d_s[PW-1];
      k_s         = {1'b0, d_s[PW-2:0]};
      capture_l_s = sample && !right_ch_s && (k_s < BITS_P);
      capture_r_s = sample &&  right_ch_s && (k_s < BITS_P);
      latch_l_s   = capture_l_s && (k_s == LAST_P) && (left_arm_r  || (k_s == ZERO_P));
      latch_r_s   = capture_r_s && (k_s == LAST_P) && (right_arm_r || (k_s == ZERO_P));
   end

   generate
      if (BITS == 1) begin : g_single
         // A one-bit word is just the sampled bit.
         always_comb begin
            left_nxt_s  = sd;
            right_nxt_s = sd;
         end
      end else begin : g_multi
         // Next shift value; also the word loaded on the last bit.
         always_comb begin
            left_nxt_s  = {left_sh_r[BITS-2:0], sd};
            right_nxt_s = {right_sh_r[BITS-2:0], sd};
         end
      end
   endgenerate

   // Shift registers, MSB-seen flags and registered outputs.
   always_ff @(posedge ck) begin
      if (!rst_n) begin
         left_sh_r   <= {BITS{1'b0}};
         right_sh_r  <= {BITS{1'b0}};
         left_arm_r  <= 1'b0;
         right_arm_r <= 1'b0;
         left        <= {BITS{1'b0}};
         right       <= {BITS{1'b0}};
      end else begin
         if (capture_l_s) begin
            left_sh_r <= left_nxt_s;
            if (k_s == ZERO_P) begin
               left_arm_r <= 1'b1;
            end
         end
         if (capture_r_s) begin
            right_sh_r <= right_nxt_s;
            if (k_s == ZERO_P) begin
               right_arm_r <= 1'b1;
            end
         end
         if (latch_l_s) begin
            left <= left_nxt_s;
         end
         if (latch_r_s) begin
            right <= right_nxt_s;
         end
      end
   end

`ifdef I2S_RX_READY_EN
   // Stereo-pair strobe, coincident with the right word update.
   always_ff @(posedge ck) begin
      if (!rst_n) begin
         ready <= 1'b0;
      end else begin
         ready <= latch_r_s;
      end
   end
`endif

endmodule

// File: tb/tb_i2s_rx_deserialiser.sv
// Self-checking bench: three instances (64/24, 64/16, 32/16) fed from a slot-indexed word model,
// checked every cycle plus table-driven frame-end expectations and a mid-word reset sequence.
module tb_i2s_rx_deserialiser;

   logic        ck = 1'b0;
   logic        rst_n;
   logic        sample;
   logic [5:0]  frame_posn;
   logic        sd64;
   logic        sd32;
   logic [23:0] a_left, a_right;
   logic [15:0] b_left, b_right, c_left, c_right;
`ifdef I2S_RX_READY_EN
   logic        a_ready, b_ready, c_ready;
`endif

   always #5 ck = ~ck;

   i2s_rx_deserialiser #(.BITS(24), .CLOCKS(64)) dut_a (
      .ck(ck), .rst_n(rst_n), .sample(sample), .frame_posn(frame_posn), .sd(sd64),
      .left(a_left), .right(a_right)
`ifdef I2S_RX_READY_EN
      , .ready(a_ready)
`endif
   );

   i2s_rx_deserialiser #(.BITS(16), .CLOCKS(64)) dut_b (
      .ck(ck), .rst_n(rst_n), .sample(sample), .frame_posn(frame_posn), .sd(sd64),
      .left(b_left), .right(b_right)
`ifdef I2S_RX_READY_EN
      , .ready(b_ready)
`endif
   );

   i2s_rx_deserialiser #(.BITS(16), .CLOCKS(32)) dut_c (
      .ck(ck), .rst_n(rst_n), .sample(sample), .frame_posn(frame_posn), .sd(sd32),
      .left(c_left), .right(c_right)
`ifdef I2S_RX_READY_EN
      , .ready(c_ready)
`endif
   );

   // Instance configuration: frame length, output width, source stream, transmitted word width.
   localparam int IC [3] = '{64, 64, 32};
   localparam int IB [3] = '{24, 16, 16};
   localparam int IS [3] = '{0, 0, 1};
   localparam int SC [2] = '{64, 32};
   localparam int SW [2] = '{24, 16};

   typedef struct {
      logic [23:0] l64, r64;
      logic [15:0] l32, r32;
      logic [23:0] ea_l, ea_r;
      logic [15:0] eb_l, eb_r, ec_l, ec_r;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   logic [23:0] words [2][32][2];
   logic [23:0] exp_lr [3][2];
   logic        exp_rdy [3];
   int          g_next;
   int          g_first;
   vec_t        tbl [4];

   function automatic logic [23:0] word_of(input int s, input int fi, input int ch);
      if (fi < 0) return 24'h0;
      return words[s][fi][ch];
   endfunction

   // Word index of the frame a slot's bit belongs to (one-slot I2S delay).
   function automatic int frame_of(input int c, input int g);
      if (g == 0) return -1;
      return (g - 1) / c;
   endfunction

   function automatic logic tx_bit(input int s, input int g);
      int c, w, d, k, ch;
      logic [23:0] wd;
      c  = SC[s];
      w  = SW[s];
      d  = (g + c - 1) % c;
      ch = (d >= c / 2) ? 1 : 0;
      k  = d % (c / 2);
      wd = word_of(s, frame_of(c, g), ch);
      if (k >= w) return 1'b0;
      return wd[w - 1 - k];
   endfunction

   // Expected effect of one accepted sample of slot g on instance i.
   task automatic model_sample(input int i, input int g);
      int c, b, s, d, k, ch;
      c  = IC[i];
      b  = IB[i];
      s  = IS[i];
      d  = (g + c - 1) % c;
      ch = (d >= c / 2) ? 1 : 0;
      k  = d % (c / 2);
      if (k == b - 1 && (g - (b - 1)) >= g_first) begin
         exp_lr[i][ch] = word_of(s, frame_of(c, g), ch) >> (SW[s] - b);
         if (ch == 1) exp_rdy[i] = 1'b1;
      end
   endtask

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("a_left",  a_left,  exp_lr[0][0]);
      chk("a_right", a_right, exp_lr[0][1]);
      chk("b_left",  {8'h00, b_left},  exp_lr[1][0]);
      chk("b_right", {8'h00, b_right}, exp_lr[1][1]);
      chk("c_left",  {8'h00, c_left},  exp_lr[2][0]);
      chk("c_right", {8'h00, c_right}, exp_lr[2][1]);
`ifdef I2S_RX_READY_EN
      chk("a_ready", {23'h0, a_ready}, {23'h0, exp_rdy[0]});
      chk("b_ready", {23'h0, b_ready}, {23'h0, exp_rdy[1]});
      chk("c_ready", {23'h0, c_ready}, {23'h0, exp_rdy[2]});
`endif
   endtask

   // One ck cycle: optionally a sample of the next slot, optionally in reset; then check.
   task automatic step(input bit smp, input bit rst);
      int g;
      @(negedge ck);
      g          = g_next;
      rst_n      = ~rst;
      sample     = smp;
      frame_posn = 6'(g % 64);
      sd64       = tx_bit(0, g);
      sd32       = tx_bit(1, g);
      @(posedge ck);
      #1;
      for (int i = 0; i < 3; i++) begin
         exp_rdy[i] = 1'b0;
         if (rst) begin
            exp_lr[i][0] = 24'h0;
            exp_lr[i][1] = 24'h0;
         end else if (smp) begin
            model_sample(i, g);
         end
      end
      if (smp) g_next = g + 1;
      if (rst) g_first = g_next;
      check_all();
   endtask

   task automatic run_slots(input int n, input int maxgap);
      for (int n_i = 0; n_i < n; n_i++) begin
         step(1'b1, 1'b0);
         repeat ($urandom_range(0, maxgap)) step(1'b0, 1'b0);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      sample     = 1'b0;
      frame_posn = 6'd0;
      sd64       = 1'b0;
      sd32       = 1'b0;
      g_next     = 0;
      g_first    = 0;
      for (int i = 0; i < 3; i++) begin
         exp_lr[i][0] = 24'h0;
         exp_lr[i][1] = 24'h0;
         exp_rdy[i]   = 1'b0;
      end
      for (int s = 0; s < 2; s++)
         for (int f = 0; f < 32; f++) begin
            words[s][f][0] = 24'h0;
            words[s][f][1] = 24'h0;
         end

      tbl[0] = '{24'hF0F0F0, 24'hCAFEDB, 16'hFACE, 16'h1234,
                 24'hF0F0F0, 24'hCAFEDB, 16'hF0F0, 16'hCAFE, 16'hFACE, 16'h1234};
      tbl[1] = '{24'h123456, 24'hFFFFFF, 16'hFFFF, 16'h0000,
                 24'h123456, 24'hFFFFFF, 16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000};
      tbl[2] = '{24'h000000, 24'hAAAAAA, 16'h0000, 16'hFFFF,
                 24'h000000, 24'hAAAAAA, 16'h0000, 16'hAAAA, 16'h0000, 16'hFFFF};
      tbl[3] = '{24'h555555, 24'h123456, 16'hAAAA, 16'h5555,
                 24'h555555, 24'h123456, 16'h5555, 16'h1234, 16'hAAAA, 16'h5555};

      repeat (3) step(1'b0, 1'b1);
      step(1'b1, 1'b0);

      // Directed frames from the table; frame-end values checked against the table constants.
      for (int f = 0; f < 4; f++) begin
         words[0][f][0]         = tbl[f].l64;
         words[0][f][1]         = tbl[f].r64;
         words[1][2 * f][0]     = {8'h00, tbl[f].l32};
         words[1][2 * f][1]     = {8'h00, tbl[f].r32};
         words[1][2 * f + 1][0] = {8'h00, tbl[f].l32};
         words[1][2 * f + 1][1] = {8'h00, tbl[f].r32};
         run_slots(17, f % 2);
         chk("tbl_c_left_mid", {8'h00, c_left}, {8'h00, tbl[f].ec_l});
         run_slots(47, f % 2);
         chk("tbl_a_left",  a_left,  tbl[f].ea_l);
         chk("tbl_a_right", a_right, tbl[f].ea_r);
         chk("tbl_b_left",  {8'h00, b_left},  {8'h00, tbl[f].eb_l});
         chk("tbl_b_right", {8'h00, b_right}, {8'h00, tbl[f].eb_r});
         chk("tbl_c_left",  {8'h00, c_left},  {8'h00, tbl[f].ec_l});
         chk("tbl_c_right", {8'h00, c_right}, {8'h00, tbl[f].ec_r});
      end

      // Randomized frames with random sample spacing.
      for (int f = 4; f < 10; f++) begin
         words[0][f][0]         = 24'($urandom);
         words[0][f][1]         = 24'($urandom);
         words[1][2 * f][0]     = {8'h00, 16'($urandom)};
         words[1][2 * f][1]     = {8'h00, 16'($urandom)};
         words[1][2 * f + 1][0] = {8'h00, 16'($urandom)};
         words[1][2 * f + 1][1] = {8'h00, 16'($urandom)};
         run_slots(64, 2);
      end

      // Reset in the middle of the left word, then two more frames.
      for (int f = 10; f < 12; f++) begin
         words[0][f][0]         = 24'($urandom);
         words[0][f][1]         = 24'($urandom);
         words[1][2 * f][0]     = {8'h00, 16'($urandom)};
         words[1][2 * f][1]     = {8'h00, 16'($urandom)};
         words[1][2 * f + 1][0] = {8'h00, 16'($urandom)};
         words[1][2 * f + 1][1] = {8'h00, 16'($urandom)};
      end
      run_slots(10, 1);
      repeat (3) step(1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b1);
      chk("rst_a_left_zero", a_left, 24'h0);
      run_slots(14, 1);
      chk("rst_partial_left_dropped", a_left, 24'h0);
      run_slots(37, 1);
      run_slots(64, 1);
      chk("rst_a_left_recovered",  a_left,  words[0][11][0]);
      chk("rst_a_right_recovered", a_right, words[0][11][1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
